// File: rtl/ram_burst_reader_pkg.sv
// Shared types and helpers for the RAM burst reader: state encoding,
// default geometry and the burst-length clamp.
package ram_burst_reader_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FINISH
  } state_t;

  // A burst can never cover more words than the RAM holds.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/ram_burst_reader_if.sv
// Control, RAM read-port and output-stream signals of the burst reader.
// Optional out_parity exists only when RAM_BURST_READER_PARITY_EN is defined.
interface ram_burst_reader_if
  import ram_burst_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   burst_len;
  logic              abort;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              done;
`ifdef RAM_BURST_READER_PARITY_EN
  logic              out_parity;
`endif

  modport master (
    input  start, start_addr, burst_len, abort, ram_rdata, out_ready,
    output ram_addr, ram_en, out_data, out_valid, out_last, busy, done
`ifdef RAM_BURST_READER_PARITY_EN
    , output out_parity
`endif
  );

  modport slave (
    output start, start_addr, burst_len, abort, ram_rdata, out_ready,
    input  ram_addr, ram_en, out_data, out_valid, out_last, busy, done
`ifdef RAM_BURST_READER_PARITY_EN
    , input out_parity
`endif
  );

endinterface

// File: rtl/ram_burst_reader.sv
// Walks an address range on the RAM's asynchronous read port and emits each
// word as a valid/ready beat; RAM_BURST_READER_PARITY_EN adds out_parity.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic                clk,
  input logic                rst,
  ram_burst_reader_if.master bus
);

  localparam int              REM_W   = ADDR_W + 1;
  localparam int unsigned     DEPTH   = 1 << ADDR_W;
  localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              ram_en_q, ram_en_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer;
  logic              capture;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    ram_en_d = ram_en_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    capture  = 1'b0;
    xfer     = valid_q && bus.out_ready;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          addr_d = bus.start_addr;
          rem_d  = REM_W'(clamp_len(32'(bus.burst_len), DEPTH));
          if (bus.burst_len == '0) begin
            state_d = FINISH;
          end else begin
            state_d  = READ;
            ram_en_d = 1'b1;
          end
        end
      end
      READ: begin
        // One-entry holding register: refill when empty or draining this edge.
        capture = !valid_q || xfer;
        if (capture) begin
          data_d  = bus.ram_rdata;
          valid_d = 1'b1;
          last_d  = (rem_q == REM_ONE);
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d  = DRAIN;
            ram_en_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over any capture or transfer in the same cycle.
    if (state_q != IDLE && bus.abort) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      last_d   = 1'b0;
      ram_en_d = 1'b0;
      capture  = 1'b0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      ram_en_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      ram_en_q <= ram_en_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef RAM_BURST_READER_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (capture) begin
      par_d = ^bus.ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign bus.out_parity = par_q;
`endif

  assign bus.ram_addr  = addr_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader against a 16-word RAM preloaded with i+1.
module tb_ram_burst_reader;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  ram_burst_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_burst_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  assign bus.ram_rdata = bus.ram_en ? mem[bus.ram_addr] : '0;

  int n_checks = 0;
  int n_errors = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  beat_t exp_q [$];
  int    addr_q [$];

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: compares every transfer, every RAM read and back-pressure holds.
  logic          stall_prev  = 1'b0;
  logic          done_expect = 1'b0;
  logic [DW-1:0] held_data   = '0;
  logic          held_last   = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev  = 1'b0;
      done_expect = 1'b0;
    end else begin
      if (done_expect) begin
        chk("done_after_last", int'(bus.done), 1);
        done_expect = 1'b0;
      end
      if (bus.done) done_cnt++;
      if (bus.ram_en && (!bus.out_valid || bus.out_ready)) begin
        chk("read_expected", int'(addr_q.size() > 0), 1);
        if (addr_q.size() > 0) chk("ram_addr", int'(bus.ram_addr), addr_q.pop_front());
      end
      if (bus.out_valid && stall_prev) begin
        chk("hold_data", int'(bus.out_data), int'(held_data));
        chk("hold_last", int'(bus.out_last), int'(held_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        xfer_cnt++;
        chk("beat_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_data", int'(bus.out_data), int'(e.data));
          chk("out_last", int'(bus.out_last), int'(e.last));
`ifdef RAM_BURST_READER_PARITY_EN
          chk("out_parity", int'(bus.out_parity), int'(^e.data));
`endif
        end
        if (bus.out_last) done_expect = 1'b1;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_data  = bus.out_data;
      held_last  = bus.out_last;
    end
  end

  // Expected word at address x is x+1 (hand-derived from the preload).
  task automatic do_start(input int a, input int len);
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = DW'(((a + i) % DEPTH) + 1);
      b.last = (i == n - 1);
      exp_q.push_back(b);
      addr_q.push_back((a + i) % DEPTH);
    end
    bus.start      = 1'b1;
    bus.start_addr = AW'(a);
    bus.burst_len  = (AW + 1)'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.busy && k < 200);
    chk({name, "_idle"}, int'(bus.busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_drained(input string name);
    chk({name, "_beats_left"}, exp_q.size(), 0);
    chk({name, "_reads_left"}, addr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int d0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.start_addr = '0;
    bus.burst_len = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_ram_addr", int'(bus.ram_addr), 0);
    chk("rst_ram_en", int'(bus.ram_en), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
`ifdef RAM_BURST_READER_PARITY_EN
    chk("rst_parity", int'(bus.out_parity), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Full 16-word burst at full rate.
    base = xfer_cnt;
    d0   = done_cnt;
    do_start(0, 16);
    chk("lat_ram_en", int'(bus.ram_en), 1);
    chk("lat_ram_addr", int'(bus.ram_addr), 0);
    chk("lat_valid_low", int'(bus.out_valid), 0);
    chk("lat_busy", int'(bus.busy), 1);
    repeat (17) @(posedge clk);
    chk("full_throughput", xfer_cnt - base, 16);
    wait_idle("full");
    chk("full_done_cnt", done_cnt - d0, 1);
    check_drained("full");

    // Address wrap 14,15,0,1.
    d0 = done_cnt;
    do_start(14, 4);
    wait_idle("wrap");
    chk("wrap_done_cnt", done_cnt - d0, 1);
    check_drained("wrap");

    // Back-pressure 1,0,0 pattern plus a start pulse while busy.
    base = xfer_cnt;
    d0   = done_cnt;
    do_start(3, 5);
    for (int c = 0; c < 60 && xfer_cnt < base + 5; c++) begin
      bus.out_ready = (c % 3 == 0);
      bus.start     = (c == 4);
      if (c == 4) begin
        bus.start_addr = '0;
        bus.burst_len  = 5'd3;
      end
      @(posedge clk); #1;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle("bp");
    chk("bp_xfers", xfer_cnt - base, 5);
    chk("bp_done_cnt", done_cnt - d0, 1);
    check_drained("bp");

    // Zero-length burst.
    d0 = done_cnt;
    do_start(7, 0);
    chk("len0_busy", int'(bus.busy), 1);
    chk("len0_done", int'(bus.done), 1);
    chk("len0_ram_en", int'(bus.ram_en), 0);
    chk("len0_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk("len0_busy_after", int'(bus.busy), 0);
    chk("len0_done_after", int'(bus.done), 0);
    chk("len0_done_cnt", done_cnt - d0, 1);

    // Abort after the second transfer of an 8-word burst.
    base = xfer_cnt;
    d0   = done_cnt;
    do_start(0, 8);
    for (int k = 0; k < 50 && xfer_cnt < base + 2; k++) @(posedge clk);
    #1;
    bus.abort     = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_valid", int'(bus.out_valid), 0);
    chk("abort_last", int'(bus.out_last), 0);
    chk("abort_ram_en", int'(bus.ram_en), 0);
    chk("abort_busy", int'(bus.busy), 0);
    repeat (4) @(posedge clk); #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_xfers", xfer_cnt - base, 2);
    chk("abort_beats_left", exp_q.size(), 6);
    chk("abort_reads_left", addr_q.size(), 5);
    exp_q.delete();
    addr_q.delete();
    bus.out_ready = 1'b1;
    d0 = done_cnt;
    do_start(5, 2);
    wait_idle("post_abort");
    chk("post_abort_done_cnt", done_cnt - d0, 1);
    check_drained("post_abort");

    // Asynchronous reset between clock edges in mid-burst.
    do_start(0, 16);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ram_en", int'(bus.ram_en), 0);
    chk("mid_rst_ram_addr", int'(bus.ram_addr), 0);
    chk("mid_rst_out_data", int'(bus.out_data), 0);
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_last", int'(bus.out_last), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
`ifdef RAM_BURST_READER_PARITY_EN
    chk("mid_rst_parity", int'(bus.out_parity), 0);
`endif
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Oversized length clamps to the RAM depth.
    base = xfer_cnt;
    d0   = done_cnt;
    do_start(8, 20);
    wait_idle("clamp");
    chk("clamp_xfers", xfer_cnt - base, 16);
    chk("clamp_done_cnt", done_cnt - d0, 1);
    check_drained("clamp");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side initiator for the 16x8 dual-port RAM.
- Drives the RAM's asynchronous read port (address plus port enable) and walks a programmed address range.
- Returns each word as a valid/ready stream beat, with a last flag on the final word.
- Sits between the RAM's read port and any downstream consumer, for example a UART TX or a checksum unit.

Parameters:
- DATA_W, 8, RAM word width.
- ADDR_W, 4, RAM address width; depth is 2**ADDR_W, so 16 by default.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to begin a burst; sampled in IDLE only.
- start_addr  input  ADDR_W  first RAM address of the burst.
- burst_len  input  ADDR_W+1  number of words, 0..2**ADDR_W.
- abort  input  1  cancels the burst in progress.
- ram_addr  output  ADDR_W  RAM read-port address.
- ram_en  output  1  RAM read-port enable.
- ram_rdata  input  DATA_W  RAM read data; combinational from ram_addr/ram_en.
- out_data  output  DATA_W  stream data.
- out_valid  output  1  stream valid.
- out_last  output  1  marks the final beat of the burst.
- out_ready  input  1  consumer ready.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: state IDLE; ram_addr=0, ram_en=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0. Reset is asynchronous and legal mid-burst; any beat in flight is discarded.
- All outputs are registered.
- The output holding register has one entry. A beat transfers when out_valid=1 and out_ready=1 on the same rising edge.
- IDLE, on start=1:
  - Latch cur_addr=start_addr and remaining=min(burst_len, 2**ADDR_W).
  - If burst_len=0: go to FINISH, so done pulses the next cycle and no beat is produced.
  - Otherwise: go to READ, with ram_en=1 and ram_addr=start_addr from the next cycle.
- READ:
  - ram_en=1 and ram_addr=cur_addr.
  - Capture condition: holding register empty, or the current beat transfers this cycle.
  - When the capture condition holds: out_data<=ram_rdata, out_valid<=1, out_last<=(remaining==1), cur_addr<=cur_addr+1 modulo 2**ADDR_W, remaining<=remaining-1.
  - When the last word is captured: go to DRAIN.
  - With out_ready held high, throughput is one beat per clock.
- DRAIN:
  - ram_en=0.
  - When the last beat transfers: out_valid<=0, out_last<=0, then go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE. busy is still 1 in FINISH.
- Latency: start sampled at edge N; ram_en rises after N; first out_valid rises after N+1.
- Back-pressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable and cur_addr does not advance.
- Address wrap: start_addr=14 with len=4 reads addresses 14, 15, 0, 1.
- start while busy is ignored.
- abort in any non-IDLE state:
  - Next cycle: out_valid=0, out_last=0, ram_en=0, state IDLE.
  - No done pulse.
  - abort has priority over a simultaneous transfer; that beat counts as consumed and nothing is emitted after it.
- abort in IDLE has no effect. abort and start in the same IDLE cycle: start is ignored.

Optional Feature:
- Macro: RAM_BURST_READER_PARITY_EN.
- When defined:
  - Extra output out_parity (1 bit) = even parity (XOR-reduce) of the captured word, registered alongside out_data.
  - Reset value 0.
  - Held stable under back-pressure.
- When undefined: the port does not exist and there is no parity logic.

Decomposition:
- Package ram_burst_reader_pkg holds:
  - The state enum: IDLE, READ, DRAIN, FINISH.
  - Default DATA_W/ADDR_W localparams.
  - A length-clamp function.
- Sub-module: none needed. The output holding register stays inline; optionally factor it as ram_rd_stream_reg if reused elsewhere.

Test Plan:
- Preload RAM[i]=i+1 for all 16 addresses. Run start_addr=0, len=16 with ready=1 → beats 1..16 on consecutive cycles; out_last only on 16; done one cycle after the last transfer.
- start_addr=14, len=4 → data 15, 16, 1, 2; ram_addr sequence 14, 15, 0, 1.
- len=5 from addr 3 with out_ready toggling 1,0,0,1… → data 4..8, each held stable while ready=0; exactly 5 transfers; no duplicates or drops.
- len=0 → no out_valid; busy high for one cycle; done pulse.
- Abort: abort asserted after the 2nd transfer of a len=8 burst → out_valid low next cycle, no done, IDLE. A new start then works normally.
- Reset mid-burst: rst asserted asynchronously (between edges) mid-burst → all outputs 0 immediately. With the parity macro defined, word 0x07 → out_parity=1 and word 0x03 → out_parity=0.
